// File: rtl/temp_top_level_pkg.sv
// temp_top_level_pkg: shared widths, pass/gap constants, FSM states and lane slicing for the block-multiply datapath.
package temp_top_level_pkg;
  localparam int LANES = 16;
  localparam int ELEM_W = 16;
  localparam int ACC_PASSES = 16;
  localparam int GAP = 3;
  localparam int VEC_W = LANES * ELEM_W;
  localparam int CNT_W = $clog2(GAP);
  localparam int PASS_W = $clog2(ACC_PASSES);
  typedef enum logic [1:0] {S_WAIT, S_RUN, S_DONE} state_e;
  function automatic logic [ELEM_W-1:0] lane_of(input logic [VEC_W-1:0] v, input int i);
    return v[i*ELEM_W +: ELEM_W];
  endfunction
endpackage

// File: rtl/temp_top_level_mac_lane.sv
// mac_lane: one lane's product skew pipeline (DEPTH stages) feeding a wrapping 16-bit accumulator.
module mac_lane
  import temp_top_level_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              en,
  input  logic              clr,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] acc_d
);
  logic [ELEM_W-1:0] p_q [DEPTH];
  logic [ELEM_W-1:0] p_d [DEPTH];
  logic [ELEM_W-1:0] acc_q;
  // The product is captured at the pass start so later input changes cannot disturb the pass.
  always_comb begin
    p_d[0] = start ? a * b : p_q[0];
    for (int k = 1; k < DEPTH; k++) p_d[k] = p_q[k-1];
    acc_d = clr ? '0 : en ? acc_q + p_q[DEPTH-1] : acc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) p_q[k] <= '0;
      acc_q <= '0;
    end else begin
      p_q <= p_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/temp_top_level.sv
// temp_top_level: 16-lane skewed multiply-accumulate; sums ACC_PASSES passes and publishes the block on out.
module temp_top_level
  import temp_top_level_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             reset_accum,
  input  logic [VEC_W-1:0] input_1,
  input  logic [VEC_W-1:0] input_2,
  output logic [VEC_W-1:0] out,
  output logic             done_systolic,
  output logic             done_accum
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [LANES-1:0] tok_q, tok_d;
  logic clr_pend_q, clr_pend_d, done_accum_q, done_accum_d;
  logic [VEC_W-1:0] out_q, out_d, sums;
  logic start, last, fin, clr;
  // tok_q[i] marks the cycle whose closing edge lets lane i add its product.
  always_comb begin
    start = state_q == S_WAIT && cnt_q == CNT_W'(GAP - 1);
    last = state_q == S_RUN && tok_q[LANES-1];
    fin = last && pass_q == PASS_W'(ACC_PASSES - 1) && !reset_accum;
    clr = reset_accum || (start && clr_pend_q);
    state_d = reset_accum ? S_WAIT : start ? S_RUN : last ? S_DONE : state_q == S_DONE ? S_WAIT : state_q;
    cnt_d = (reset_accum || last || start) ? '0 : state_q != S_RUN ? cnt_q + 1'b1 : cnt_q;
    pass_d = (reset_accum || fin) ? '0 : last ? pass_q + 1'b1 : pass_q;
    tok_d = reset_accum ? '0 : {tok_q[LANES-2:0], start};
    clr_pend_d = reset_accum ? 1'b0 : fin ? 1'b1 : start ? 1'b0 : clr_pend_q;
    done_accum_d = fin;
    out_d = fin ? sums : out_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_WAIT;
      cnt_q <= CNT_W'(GAP - 1);
      pass_q <= '0;
      tok_q <= '0;
      clr_pend_q <= 1'b0;
      done_accum_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pass_q <= pass_d;
      tok_q <= tok_d;
      clr_pend_q <= clr_pend_d;
      done_accum_q <= done_accum_d;
      out_q <= out_d;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.DEPTH(i + 1)) u_lane (
      .clk  (clock),
      .rst_n(reset),
      .start(start),
      .en   (tok_q[i]),
      .clr  (clr),
      .a    (lane_of(input_1, i)),
      .b    (lane_of(input_2, i)),
      .acc_d(sums[i*ELEM_W +: ELEM_W])
    );
  end
  assign out = out_q;
  assign done_accum = done_accum_q;
  assign done_systolic = state_q == S_DONE;
endmodule

// File: tb/tb_temp_top_level.sv
// tb_temp_top_level: directed blocks with a scoreboard of expected out values, popped on each done_accum.
module tb_temp_top_level;
  logic clock = 1'b0, reset = 1'b0, reset_accum = 1'b0;
  logic [255:0] input_1 = '0, input_2 = '0, out;
  logic done_systolic, done_accum;
  int total = 0, passed = 0, cyc = -1, acc_cyc = -1;
  logic [255:0] sb[$];
  int ds_cyc[$];

  temp_top_level dut (
    .clock(clock), .reset(reset), .reset_accum(reset_accum),
    .input_1(input_1), .input_2(input_2), .out(out),
    .done_systolic(done_systolic), .done_accum(done_accum)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset)
    if (!reset) cyc <= -1;
    else cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endfunction

  function automatic logic [255:0] rep(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic wait_ds(input int n);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!done_systolic && t < 40);
      if (!done_systolic) begin
        total++;
        $display("FAIL ds_timeout: pulse %0d of %0d missing after 40 cycles", k + 1, n);
      end
    end
  endtask

  always @(negedge clock) begin
    if (done_systolic && ds_cyc.size() < 3) ds_cyc.push_back(cyc);
    if (done_accum) begin
      chk("accum_with_systolic", done_systolic, 1);
      if (acc_cyc < 0) acc_cyc = cyc;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done_accum: out=%h with nothing expected", out);
      end else chk("block_out", out, sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [255:0] va, ve;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_out", out, 0);
    chk("rst_done_systolic", done_systolic, 0);
    chk("rst_done_accum", done_accum, 0);
    input_1 = rep(16'h0001);
    input_2 = rep(16'h0002);
    sb.push_back(rep(16'h0020));
    @(negedge clock) reset = 1'b1;
    wait_ds(16);
    #1;
    chk("blk1_done", sb.size(), 0);
    chk("ds_count", ds_cyc.size(), 3);
    if (ds_cyc.size() >= 3) begin
      chk("ds_edge0", ds_cyc[0], 16);
      chk("ds_edge1", ds_cyc[1], 35);
      chk("ds_edge2", ds_cyc[2], 54);
    end
    chk("accum_edge", acc_cyc, 301);
    for (int i = 0; i < 16; i++) begin
      va[i*16 +: 16] = 16'(i);
      ve[i*16 +: 16] = 16'(16 * i);
    end
    input_1 = va;
    input_2 = rep(16'h0001);
    for (int r = 0; r < 2; r++) begin
      sb.push_back(ve);
      wait_ds(16);
      #1 chk("ramp_done", sb.size(), 0);
    end
    input_1 = rep(16'hFFFF);
    input_2 = rep(16'hFFFF);
    sb.push_back(rep(16'h0010));
    wait_ds(16);
    #1 chk("ovf_done", sb.size(), 0);
    input_1 = rep(16'h0005);
    input_2 = rep(16'h0001);
    wait_ds(5);
    reset_accum = 1'b1;
    @(negedge clock) reset_accum = 1'b0;
    chk("racc_out_held", out, rep(16'h0010));
    input_1 = rep(16'h0003);
    sb.push_back(rep(16'h0030));
    wait_ds(11);
    #1 chk("racc_not_early", sb.size(), 1);
    wait_ds(5);
    #1 chk("racc_done", sb.size(), 0);
    input_1 = rep(16'h0007);
    wait_ds(2);
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_done_systolic", done_systolic, 0);
    chk("mid_rst_done_accum", done_accum, 0);
    sb.push_back(rep(16'h0070));
    @(negedge clock) reset = 1'b1;
    wait_ds(16);
    #1 chk("rerun_done", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
